mips_mem_arbiter: RTL and testbench

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

---
 rtl/mips_arb_pkg.sv | 32 +++
 rtl/mips_arb_prio.sv | 76 +++++++
 rtl/mips_mem_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the MIPS unified-memory arbiter.
// Optional debug requester is enabled by defining MEM_ARB_DBG_PORT_EN.
package mips_arb_pkg;

    localparam int SRC_W = 2;
    localparam int CNT_W = 4;
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [SRC_W-1:0] {
        SRC_DM  = 2'd0,
        SRC_IF  = 2'd1,
        SRC_DBG = 2'd2
    } src_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                 input logic [CNT_W-1:0] lim);
        logic [CNT_W-1:0] res;
        if (val >= lim) begin
            res = lim;
        end else begin
            res = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/mips_arb_prio.sv
// Winner selection and fetch-starvation tracking for mips_mem_arbiter.
// Adds the lowest-priority debug requester when MEM_ARB_DBG_PORT_EN is defined.
module mips_arb_prio
    import mips_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic arb_en,
    input  logic halted,
    input  logic if_req,
    input  logic dm_req,
`ifdef MEM_ARB_DBG_PORT_EN
    input  logic dbg_req,
    output logic dbg_win,
`endif
    output logic if_win,
    output logic dm_win
);

    logic [CNT_W-1:0] starve_cnt_r;
    logic             starved_s;
    logic             if_ok_s;
    logic             if_win_s;
    logic             dm_win_s;
`ifdef MEM_ARB_DBG_PORT_EN
    logic             dbg_win_s;
`endif

    assign starved_s = (starve_cnt_r == CNT_W'(STARVE_MAX));
    assign if_ok_s   = if_req && !halted;

    // Priority: a starved fetch first, then data, then fetch, then debug.
    always_comb begin
        if_win_s  = 1'b0;
        dm_win_s  = 1'b0;
`ifdef MEM_ARB_DBG_PORT_EN
        dbg_win_s = 1'b0;
`endif
        if (arb_en && if_ok_s && starved_s) begin
            if_win_s = 1'b1;
        end else if (arb_en && dm_req) begin
            dm_win_s = 1'b1;
        end else if (arb_en && if_ok_s) begin
            if_win_s = 1'b1;
`ifdef MEM_ARB_DBG_PORT_EN
        end else if (arb_en && dbg_req) begin
            dbg_win_s = 1'b1;
`endif
        end else begin
            if_win_s = 1'b0;
            dm_win_s = 1'b0;
        end
    end

    // Count data grants that bypass a waiting fetch; debug grants are not counted.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!if_req || if_win_s) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (dm_win_s) begin
            starve_cnt_r <= sat_inc(starve_cnt_r, CNT_W'(STARVE_MAX));
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign if_win  = if_win_s;
    assign dm_win  = dm_win_s;
`ifdef MEM_ARB_DBG_PORT_EN
    assign dbg_win = dbg_win_s;
`endif

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one single-ported memory between fetch, data and (with
// MEM_ARB_DBG_PORT_EN defined) a debug requester; one access in flight.
module mips_mem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              halted,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
`ifdef MEM_ARB_DBG_PORT_EN
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_r;
    state_e            state_nxt_s;
    src_e              src_r;
    src_e              win_src_s;
    logic [LAT_W-1:0]  lat_cnt_r;
    logic              lat_done_s;
    logic              arb_en_s;
    logic              if_win_s;
    logic              dm_win_s;
    logic              any_win_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic              if_rvalid_r;
    logic              dm_rvalid_r;
`ifdef MEM_ARB_DBG_PORT_EN
    logic              dbg_win_s;
    logic              dbg_rvalid_r;
`endif

    // Grants only from IDLE, and never while reset is asserted.
    assign arb_en_s   = rst_n && (state_r == ST_IDLE);
    assign lat_done_s = (lat_cnt_r == LAT_W'(MEM_LAT - 1));

    mips_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .arb_en  (arb_en_s),
        .halted  (halted),
        .if_req  (if_req),
        .dm_req  (dm_req),
`ifdef MEM_ARB_DBG_PORT_EN
        .dbg_req (dbg_req),
        .dbg_win (dbg_win_s),
`endif
        .if_win  (if_win_s),
        .dm_win  (dm_win_s)
    );

`ifdef MEM_ARB_DBG_PORT_EN
    assign any_win_s = if_win_s | dm_win_s | dbg_win_s;
`else
    assign any_win_s = if_win_s | dm_win_s;
`endif

    // Route the winning requester's command onto the memory-side registers.
    always_comb begin
        win_src_s   = SRC_DM;
        win_we_s    = dm_we;
        win_addr_s  = dm_addr;
        win_wdata_s = dm_wdata;
        if (if_win_s) begin
            win_src_s   = SRC_IF;
            win_we_s    = 1'b0;
            win_addr_s  = if_addr;
            win_wdata_s = {DATA_W{1'b0}};
`ifdef MEM_ARB_DBG_PORT_EN
        end else if (dbg_win_s) begin
            win_src_s   = SRC_DBG;
            win_we_s    = dbg_we;
            win_addr_s  = dbg_addr;
            win_wdata_s = dbg_wdata;
`endif
        end else begin
            win_src_s   = SRC_DM;
            win_we_s    = dm_we;
            win_addr_s  = dm_addr;
            win_wdata_s = dm_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_win_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (lat_done_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Latch the winner, hold the memory drive for MEM_LAT cycles, then respond.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            src_r        <= SRC_DM;
            lat_cnt_r    <= {LAT_W{1'b0}};
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            rdata_r      <= {DATA_W{1'b0}};
            if_rvalid_r  <= 1'b0;
            dm_rvalid_r  <= 1'b0;
`ifdef MEM_ARB_DBG_PORT_EN
            dbg_rvalid_r <= 1'b0;
`endif
        end else begin
            if_rvalid_r  <= 1'b0;
            dm_rvalid_r  <= 1'b0;
`ifdef MEM_ARB_DBG_PORT_EN
            dbg_rvalid_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (any_win_s) begin
                        src_r       <= win_src_s;
                        lat_cnt_r   <= {LAT_W{1'b0}};
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= win_we_s;
                        mem_addr_r  <= win_addr_s;
                        mem_wdata_r <= win_wdata_s;
                    end
                end
                ST_ACCESS: begin
                    if (lat_done_s) begin
                        mem_en_r <= 1'b0;
                        mem_we_r <= 1'b0;
                        // Stores leave the previous response word in place.
                        if (!mem_we_r) begin
                            rdata_r <= mem_rdata;
                        end
                        if (src_r == SRC_IF) begin
                            if_rvalid_r <= 1'b1;
`ifdef MEM_ARB_DBG_PORT_EN
                        end else if (src_r == SRC_DBG) begin
                            dbg_rvalid_r <= 1'b1;
`endif
                        end else begin
                            dm_rvalid_r <= 1'b1;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    end
                end
                default: begin
                    mem_en_r <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt     = if_win_s;
    assign dm_gnt     = dm_win_s;
    assign if_rvalid  = if_rvalid_r;
    assign dm_rvalid  = dm_rvalid_r;
    assign rdata      = rdata_r;
    assign mem_en     = mem_en_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
`ifdef MEM_ARB_DBG_PORT_EN
    assign dbg_gnt    = dbg_win_s;
    assign dbg_rvalid = dbg_rvalid_r;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: cycle table plus hand sequences for
// starvation, halt gating and mid-access reset.
module tb_mips_mem_arbiter;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        halted = 1'b0;
    logic        if_req = 1'b0;
    logic [9:0]  if_addr = 10'd0;
    logic        if_gnt, if_rvalid;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [9:0]  dm_addr = 10'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_DBG_PORT_EN
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [9:0]  dbg_addr = 10'd0;
    logic [31:0] dbg_wdata = 32'd0;
    logic        dbg_gnt, dbg_rvalid;
`endif

    logic [31:0] mem [0:1023];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk1 = ~clk1;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk1) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end

    mips_mem_arbiter dut (
        .clk1(clk1), .rst_n(rst_n), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
`ifdef MEM_ARB_DBG_PORT_EN
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
`endif
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ctl = {if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid}
    typedef struct packed {
        logic        if_req;
        logic        dm_req;
        logic        dm_we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [5:0]  ctl;
        logic [9:0]  maddr;
        logic [31:0] rd;
    } vec_t;

    localparam int NV = 16;
    vec_t tv [NV];

    function automatic vec_t mk(input logic ir, input logic dr, input logic we,
                                input logic [9:0] a, input logic [31:0] wd,
                                input logic [5:0] c, input logic [9:0] ma,
                                input logic [31:0] r);
        vec_t v;
        v.if_req = ir; v.dm_req = dr; v.dm_we = we; v.addr = a; v.wdata = wd;
        v.ctl = c; v.maddr = ma; v.rd = r;
        return v;
    endfunction

    function automatic logic [5:0] ctl_now();
        return {if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] order;
        int ngr, both, max_seen, viol;

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[120] = 32'd85;
        mem[5]   = 32'hDEADBEEF;

        // load 120, store 121, load 121, fetch 5
        tv[0]  = mk(1'b0, 1'b1, 1'b0, 10'd120, 32'd0,   6'b010000, 10'd0,   32'd0);
        tv[1]  = mk(1'b0, 1'b0, 1'b0, 10'd0,   32'd0,   6'b001000, 10'd120, 32'd0);
        tv[2]  = mk(1'b0, 1'b0, 1'b0, 10'd0,   32'd0,   6'b001000, 10'd120, 32'd0);
        tv[3]  = mk(1'b0, 1'b0, 1'b0, 10'd0,   32'd0,   6'b000001, 10'd0,   32'd85);
        tv[4]  = mk(1'b0, 1'b1, 1'b1, 10'd121, 32'd130, 6'b010000, 10'd0,   32'd0);
        tv[5]  = mk(1'b0, 1'b0, 1'b0, 10'd0,   32'd0,   6'b001100, 10'd121, 32'd0);
        tv[6]  = mk(1'b0, 1'b0, 1'b0, 10'd0,   32'd0,   6'b001100, 10'd121, 32'd0);
        tv[7]  = mk(1'b0, 1'b0, 1'b0, 10'd0,   32'd0,   6'b000001, 10'd0,   32'd85);
        tv[8]  = mk(1'b0, 1'b1, 1'b0, 10'd121, 32'd0,   6'b010000, 10'd0,   32'd0);
        tv[9]  = mk(1'b0, 1'b0, 1'b0, 10'd0,   32'd0,   6'b001000, 10'd121, 32'd0);
        tv[10] = mk(1'b0, 1'b0, 1'b0, 10'd0,   32'd0,   6'b001000, 10'd121, 32'd0);
        tv[11] = mk(1'b0, 1'b0, 1'b0, 10'd0,   32'd0,   6'b000001, 10'd0,   32'd130);
        tv[12] = mk(1'b1, 1'b0, 1'b0, 10'd5,   32'd0,   6'b100000, 10'd0,   32'd0);
        tv[13] = mk(1'b0, 1'b0, 1'b0, 10'd0,   32'd0,   6'b001000, 10'd5,   32'd0);
        tv[14] = mk(1'b0, 1'b0, 1'b0, 10'd0,   32'd0,   6'b001000, 10'd5,   32'd0);
        tv[15] = mk(1'b0, 1'b0, 1'b0, 10'd0,   32'd0,   6'b000010, 10'd0,   32'hDEADBEEF);

        // Reset holds everything low even with requests pending.
        dm_req = 1'b1; if_req = 1'b1;
        @(negedge clk1); #1;
        chk("reset ctl", {26'd0, ctl_now()}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        dm_req = 1'b0; if_req = 1'b0;
        @(posedge clk1); #2;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk1);
            if_req = tv[i].if_req; dm_req = tv[i].dm_req; dm_we = tv[i].dm_we;
            if_addr = tv[i].addr; dm_addr = tv[i].addr; dm_wdata = tv[i].wdata;
            #1;
            chk($sformatf("vec%0d ctl", i), {26'd0, ctl_now()}, {26'd0, tv[i].ctl});
            if (tv[i].ctl[3]) chk($sformatf("vec%0d mem_addr", i), {22'd0, mem_addr}, {22'd0, tv[i].maddr});
            if (tv[i].ctl[1] || tv[i].ctl[0]) chk($sformatf("vec%0d rdata", i), rdata, tv[i].rd);
        end

        // Both requesters held: dm x4 then if, repeating.
        @(negedge clk1);
        if_req = 1'b1; if_addr = 10'd5; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd120;
        order = 10'd0; ngr = 0; both = 0; max_seen = 0;
        for (int c = 0; c < 200 && ngr < 10; c++) begin
            if (c > 0) @(negedge clk1);
            #1;
            if (if_gnt && dm_gnt) both++;
            if (if_gnt || dm_gnt) begin
                order[ngr] = if_gnt;
                ngr++;
            end
            if (int'(dut.u_prio.starve_cnt_r) > max_seen) max_seen = int'(dut.u_prio.starve_cnt_r);
        end
        chk("starve grant count", ngr, 32'd10);
        chk("starve order", {22'd0, order}, {22'd0, 10'b1000010000});
        chk("starve both granted", both, 32'd0);
        chk("starve_cnt max", max_seen, 32'd4);
        @(negedge clk1);
        if_req = 1'b0; dm_req = 1'b0;
        repeat (5) @(negedge clk1);

        // Halted blocks fetch grants; release grants at once; halt mid-fetch is ignored.
        halted = 1'b1; if_req = 1'b1; if_addr = 10'd5;
        viol = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk1); #1;
            if (if_gnt || mem_en) viol++;
        end
        chk("halted blocks fetch", viol, 32'd0);
        @(negedge clk1);
        halted = 1'b0;
        #1;
        chk("unhalt if_gnt", {31'd0, if_gnt}, 32'd1);
        @(negedge clk1);
        if_req = 1'b0; halted = 1'b1;
        #1;
        chk("halted mid-fetch mem_en", {31'd0, mem_en}, 32'd1);
        @(negedge clk1); #1;
        @(negedge clk1); #1;
        chk("halted mid-fetch rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd2);
        chk("halted mid-fetch rdata", rdata, 32'hDEADBEEF);
        halted = 1'b0;

        // Reset during the second ACCESS cycle aborts the load.
        @(negedge clk1);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd120;
        #1;
        chk("abort dm_gnt", {31'd0, dm_gnt}, 32'd1);
        @(negedge clk1);
        dm_req = 1'b0;
        #1;
        @(negedge clk1); #2;
        rst_n = 1'b0;
        #1;
        chk("abort mem_en async", {31'd0, mem_en}, 32'd0);
        chk("abort rdata cleared", rdata, 32'd0);
        @(negedge clk1);
        rst_n = 1'b1;
        viol = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk1); #1;
            if (if_rvalid || dm_rvalid || mem_en) viol++;
        end
        chk("abort no rvalid", viol, 32'd0);
        @(negedge clk1);
        dm_req = 1'b1; dm_addr = 10'd121;
        #1;
        chk("post-reset dm_gnt", {31'd0, dm_gnt}, 32'd1);
        @(negedge clk1);
        dm_req = 1'b0;
        @(negedge clk1);
        @(negedge clk1); #1;
        chk("post-reset dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
        chk("post-reset rdata", rdata, 32'd130);

`ifdef MEM_ARB_DBG_PORT_EN
        // Debug store alone, then dm outranks debug.
        @(negedge clk1);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd0; dbg_wdata = 32'h28010078;
        #1;
        chk("dbg_gnt alone", {31'd0, dbg_gnt}, 32'd1);
        @(negedge clk1);
        dbg_req = 1'b0;
        @(negedge clk1);
        @(negedge clk1); #1;
        chk("dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        chk("dbg mem[0]", mem[0], 32'h28010078);
        @(negedge clk1);
        dbg_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd120;
        #1;
        chk("dm over dbg", {30'd0, dm_gnt, dbg_gnt}, 32'd2);
        @(negedge clk1);
        dm_req = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        @(negedge clk1); #1;
        chk("dbg after dm", {31'd0, dbg_gnt}, 32'd1);
        @(negedge clk1);
        dbg_req = 1'b0;
        repeat (4) @(negedge clk1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
